// File: rtl/ccip_c0_rd_arb_if.sv
// Requester-side and CCI-P c0 read bundle for ccip_c0_rd_arb.
// master = arbiter view, slave = AFU engines + CCI-P shell view.
interface ccip_c0_rd_arb_if #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 42,
  parameter int MDATA_W = 16
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int UM_W  = MDATA_W - IDX_W;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*UM_W-1:0]   req_mdata;
  logic [N_REQ-1:0]        req_ready;
  logic                    c0TxAlmFull;
  logic                    c0_tx_valid;
  logic [ADDR_W-1:0]       c0_tx_addr;
  logic [MDATA_W-1:0]      c0_tx_mdata;
  logic                    c0_rx_rd_valid;
  logic [MDATA_W-1:0]      c0_rx_mdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [UM_W-1:0]         rsp_mdata;
  logic [N_REQ-1:0]        outstanding_zero;
  logic                    tag_err;
  logic [N_REQ*32-1:0]     stat_grant_cnt;

  modport master (
    input  req_valid, req_addr, req_mdata,
    input  c0TxAlmFull, c0_rx_rd_valid, c0_rx_mdata,
    output req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    output rsp_valid, rsp_mdata, outstanding_zero, tag_err,
    output stat_grant_cnt
  );

  modport slave (
    output req_valid, req_addr, req_mdata,
    output c0TxAlmFull, c0_rx_rd_valid, c0_rx_mdata,
    input  req_ready, c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    input  rsp_valid, rsp_mdata, outstanding_zero, tag_err,
    input  stat_grant_cnt
  );
endinterface

// File: rtl/ccip_c0_rd_arb.sv
// Round-robin CCI-P c0 read arbiter with mdata tagging and response steering.
// Optional grant statistics: define CCIP_C0_RD_ARB_STATS_EN.
module ccip_c0_rd_arb #(
  parameter int N_REQ           = 4,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input logic pClk,
  input logic pck_cp2af_softReset,
  ccip_c0_rd_arb_if.master bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int UM_W  = MDATA_W - IDX_W;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [IDX_W:0]   N_LIM   = (IDX_W + 1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_REQ - 1);

  logic rst;
  assign rst = pck_cp2af_softReset;

  logic [CW-1:0]      cnt     [N_REQ];
  logic [CW-1:0]      cntNext [N_REQ];
  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   dec;
  logic [N_REQ-1:0]   ozNext;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gIdx;
  logic [IDX_W-1:0]   scanIdx;
  logic [IDX_W:0]     scanSum;
  logic [IDX_W-1:0]   tag;
  logic               found;
  logic               tagOk;
  logic [ADDR_W-1:0]  selAddr;
  logic [UM_W-1:0]    selUm;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req_valid[i] && (cnt[i] < MAX_CNT);
    end
  end

  // Scan from ptr with wraparound; first eligible wins.
  always_comb begin
    grant   = '0;
    gIdx    = '0;
    found   = 1'b0;
    scanSum = '0;
    scanIdx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scanSum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (scanSum >= N_LIM) begin
        scanSum = scanSum - N_LIM;
      end
      scanIdx = scanSum[IDX_W-1:0];
      if (!found && elig[scanIdx]) begin
        found          = 1'b1;
        grant[scanIdx] = 1'b1;
        gIdx           = scanIdx;
      end
    end
    if (rst || bus.c0TxAlmFull) begin
      grant = '0;
      found = 1'b0;
    end
  end

  assign bus.req_ready = grant;

  always_comb begin
    selAddr = '0;
    selUm   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        selAddr = bus.req_addr[i*ADDR_W +: ADDR_W];
        selUm   = bus.req_mdata[i*UM_W +: UM_W];
      end
    end
  end

  always_ff @(posedge pClk or posedge rst) begin
    if (rst) begin
      bus.c0_tx_valid <= 1'b0;
      bus.c0_tx_addr  <= '0;
      bus.c0_tx_mdata <= '0;
      ptr             <= '0;
    end else begin
      bus.c0_tx_valid <= found;
      if (found) begin
        bus.c0_tx_addr  <= selAddr;
        bus.c0_tx_mdata <= {gIdx, selUm};
        ptr             <= (gIdx == LAST) ? '0 : gIdx + 1'b1;
      end
    end
  end

  assign tag = bus.c0_rx_mdata[MDATA_W-1 -: IDX_W];

  // A full power-of-two tag space cannot hold an out-of-range index.
  if (N_REQ == (1 << IDX_W)) begin : gTagFull
    assign tagOk = 1'b1;
  end else begin : gTagPart
    assign tagOk = (tag < IDX_W'(N_REQ));
  end

  always_comb begin
    dec = '0;
    if (bus.c0_rx_rd_valid && tagOk) begin
      dec[tag] = 1'b1;
    end
  end

  assign bus.rsp_valid = dec;
  assign bus.rsp_mdata = bus.c0_rx_mdata[UM_W-1:0];

  always_comb begin
    ozNext = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cntNext[i] = cnt[i];
      if (grant[i] && !dec[i]) begin
        cntNext[i] = cnt[i] + 1'b1;
      end else if (dec[i] && !grant[i] && cnt[i] != '0) begin
        cntNext[i] = cnt[i] - 1'b1;
      end
      ozNext[i] = (cntNext[i] == '0);
    end
  end

  always_ff @(posedge pClk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
      bus.outstanding_zero <= '1;
      bus.tag_err          <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= cntNext[i];
      end
      bus.outstanding_zero <= ozNext;
      if (bus.c0_rx_rd_valid && !tagOk) begin
        bus.tag_err <= 1'b1;
      end
    end
  end

`ifdef CCIP_C0_RD_ARB_STATS_EN
  logic [31:0] stat [N_REQ];

  always_ff @(posedge pClk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        stat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && stat[i] != '1) begin
          stat[i] <= stat[i] + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : gStat
    assign bus.stat_grant_cnt[i*32 +: 32] = stat[i];
  end
`else
  assign bus.stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ccip_c0_rd_arb.sv
// Bench for ccip_c0_rd_arb: directed scenarios plus randomized traffic
// compared against a queue-free behavioural model of the arbiter.
module tb_ccip_c0_rd_arb;
  localparam int N    = 4;
  localparam int N3   = 3;
  localparam int AW   = 42;
  localparam int MW   = 16;
  localparam int UW   = 14;
  localparam int MAXO = 64;

`ifdef CCIP_C0_RD_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic pClk = 1'b0;
  logic rst  = 1'b1;
  int total = 0;
  int bad   = 0;

  int                mCnt  [N];
  longint unsigned   mStat [N];
  int                mPtr  = 0;
  logic              mTxV  = 1'b0;
  logic [AW-1:0]     mTxA  = '0;
  logic [MW-1:0]     mTxM  = '0;
  int                mg;

  always #5 pClk = ~pClk;

  ccip_c0_rd_arb_if #(.N_REQ(N), .ADDR_W(AW), .MDATA_W(MW)) bus ();
  ccip_c0_rd_arb_if #(.N_REQ(N3), .ADDR_W(AW), .MDATA_W(MW)) bus3 ();

  ccip_c0_rd_arb #(
    .N_REQ(N), .ADDR_W(AW), .MDATA_W(MW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .pClk(pClk),
    .pck_cp2af_softReset(rst),
    .bus(bus.master)
  );

  ccip_c0_rd_arb #(
    .N_REQ(N3), .ADDR_W(AW), .MDATA_W(MW), .MAX_OUTSTANDING(MAXO)
  ) dut3 (
    .pClk(pClk),
    .pck_cp2af_softReset(rst),
    .bus(bus3.master)
  );

  function automatic int expGrant();
    int i;
    if (rst || bus.c0TxAlmFull) return -1;
    for (int k = 0; k < N; k++) begin
      i = (mPtr + k) % N;
      if (bus.req_valid[i] && mCnt[i] < MAXO) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oneHot(int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0 && i < N) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] expOz();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mCnt[i] == 0);
    return r;
  endfunction

  // Reference: grant, 1-cycle tx register, counters with floor at zero.
  always @(posedge pClk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mCnt[i]  = 0;
        mStat[i] = 0;
      end
      mPtr = 0;
      mTxV = 1'b0;
      mTxA = '0;
      mTxM = '0;
    end else begin
      mg   = expGrant();
      mTxV = (mg >= 0);
      if (mg >= 0) begin
        mTxA = bus.req_addr[mg*AW +: AW];
        mTxM = {2'(mg), bus.req_mdata[mg*UW +: UW]};
        mPtr = (mg + 1) % N;
        if (mStat[mg] < 64'hFFFF_FFFF) mStat[mg]++;
      end
      for (int i = 0; i < N; i++) begin
        if (mg == i) mCnt[i]++;
        if (bus.c0_rx_rd_valid && int'(bus.c0_rx_mdata[15:14]) == i
            && mCnt[i] > 0) mCnt[i]--;
      end
    end
  end

  task automatic idle();
    bus.req_valid       = '0;
    bus.c0TxAlmFull     = 1'b0;
    bus.c0_rx_rd_valid  = 1'b0;
    bus.c0_rx_mdata     = '0;
    bus3.req_valid      = '0;
    bus3.req_addr       = '0;
    bus3.req_mdata      = '0;
    bus3.c0TxAlmFull    = 1'b0;
    bus3.c0_rx_rd_valid = 1'b0;
    bus3.c0_rx_mdata    = '0;
  endtask

  task automatic randData();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = AW'({$urandom(), $urandom()});
      bus.req_mdata[i*UW +: UW] = UW'($urandom());
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge pClk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.req_valid = '1;
    randData();
    @(negedge pClk);
    @(negedge pClk);
    total++;
    if (bus.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL rst_ready: got %b want 0000", bus.req_ready);
    end
    total++;
    if (bus.c0_tx_valid !== 1'b0 || bus.c0_tx_addr !== '0
        || bus.c0_tx_mdata !== '0) begin
      bad++;
      $display("FAIL rst_tx: got v=%b a=%h m=%h want 0/0/0",
               bus.c0_tx_valid, bus.c0_tx_addr, bus.c0_tx_mdata);
    end
    total++;
    if (bus.outstanding_zero !== 4'hF || bus.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_oz_err: got oz=%b err=%b want 1111/0",
               bus.outstanding_zero, bus.tag_err);
    end
    total++;
    if (bus.stat_grant_cnt !== '0) begin
      bad++;
      $display("FAIL rst_stat: got %h want 0", bus.stat_grant_cnt);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (bus.req_ready !== oneHot(k % 4)) begin
        bad++;
        $display("FAIL rr_grant%0d: got %b want %b",
                 k, bus.req_ready, oneHot(k % 4));
      end
      @(negedge pClk);
      total++;
      if (bus.c0_tx_valid !== 1'b1
          || bus.c0_tx_mdata[15:14] !== 2'(k % 4)) begin
        bad++;
        $display("FAIL rr_tx%0d: got v=%b tag=%0d want 1/%0d",
                 k, bus.c0_tx_valid, bus.c0_tx_mdata[15:14], k % 4);
      end
      total++;
      if (bus.c0_tx_addr !== bus.req_addr[(k % 4)*AW +: AW]) begin
        bad++;
        $display("FAIL rr_addr%0d: got %h want %h", k,
                 bus.c0_tx_addr, bus.req_addr[(k % 4)*AW +: AW]);
      end
    end
  endtask

  task automatic test_almfull();
    int txSeen;
    txSeen = 0;
    bus.c0TxAlmFull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (bus.req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL af_ready%0d: got %b want 0000", c, bus.req_ready);
      end
      if (c == 0) begin
        txSeen = txSeen + int'(bus.c0_tx_valid);
      end else begin
        total++;
        if (bus.c0_tx_valid !== 1'b0) begin
          bad++;
          $display("FAIL af_quiet%0d: got %b want 0", c, bus.c0_tx_valid);
        end
      end
      @(negedge pClk);
    end
    total++;
    if (txSeen > 1) begin
      bad++;
      $display("FAIL af_first: got %0d want <=1", txSeen);
    end
    bus.c0TxAlmFull = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL af_resume: got %b want 0010", bus.req_ready);
    end
    @(negedge pClk);
    total++;
    if (bus.c0_tx_valid !== 1'b1 || bus.c0_tx_mdata[15:14] !== 2'd1) begin
      bad++;
      $display("FAIL af_resume_tx: got v=%b tag=%0d want 1/1",
               bus.c0_tx_valid, bus.c0_tx_mdata[15:14]);
    end
  endtask

  task automatic test_credit();
    int acc;
    doReset();
    idle();
    randData();
    bus.req_valid = 4'b0100;
    acc = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) begin
        total++;
        if (bus.outstanding_zero[2] !== 1'b0) begin
          bad++;
          $display("FAIL credit_oz%0d: got 1 want 0", c);
        end
      end
      #1;
      total++;
      if (bus.req_ready !== oneHot(expGrant())) begin
        bad++;
        $display("FAIL credit_ready%0d: got %b want %b",
                 c, bus.req_ready, oneHot(expGrant()));
      end
      if (bus.req_ready[2]) acc++;
      @(negedge pClk);
    end
    total++;
    if (acc != MAXO) begin
      bad++;
      $display("FAIL credit_accepts: got %0d want %0d", acc, MAXO);
    end
    bus.c0_rx_rd_valid = 1'b1;
    bus.c0_rx_mdata    = {2'd2, 14'h1234};
    #1;
    total++;
    if (bus.rsp_valid !== 4'b0100 || bus.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL credit_rsp: got rsp=%b rdy=%b want 0100/0000",
               bus.rsp_valid, bus.req_ready);
    end
    @(negedge pClk);
    bus.c0_rx_rd_valid = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.req_ready[2]) acc++;
      @(negedge pClk);
    end
    total++;
    if (acc != 1 || bus.outstanding_zero[2] !== 1'b0) begin
      bad++;
      $display("FAIL credit_refill: got acc=%0d oz=%b want 1/0",
               acc, bus.outstanding_zero[2]);
    end
  endtask

  task automatic test_simul();
    logic [UW-1:0] r;
    doReset();
    idle();
    randData();
    bus.req_valid = 4'b0010;
    @(negedge pClk);
    @(negedge pClk);
    r = UW'($urandom());
    bus.c0_rx_rd_valid = 1'b1;
    bus.c0_rx_mdata    = {2'd1, r};
    #1;
    total++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_mdata !== r
        || bus.req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL simul_rsp: got rsp=%b md=%h rdy=%b want 0010/%h/0010",
               bus.rsp_valid, bus.rsp_mdata, bus.req_ready, r);
    end
    @(negedge pClk);
    bus.req_valid = '0;
    @(negedge pClk);
    total++;
    if (bus.outstanding_zero[1] !== 1'b0) begin
      bad++;
      $display("FAIL simul_one_left: got 1 want 0");
    end
    @(negedge pClk);
    total++;
    if (bus.outstanding_zero[1] !== 1'b1) begin
      bad++;
      $display("FAIL simul_drained: got 0 want 1");
    end
    bus.c0_rx_rd_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [MW-1:0] md;
    doReset();
    idle();
    for (int c = 0; c < 400; c++) begin
      total++;
      if (bus.c0_tx_valid !== mTxV) begin
        bad++;
        $display("FAIL rnd_txv%0d: got %b want %b", c, bus.c0_tx_valid, mTxV);
      end
      if (mTxV) begin
        total++;
        if (bus.c0_tx_addr !== mTxA || bus.c0_tx_mdata !== mTxM) begin
          bad++;
          $display("FAIL rnd_txd%0d: got %h/%h want %h/%h", c,
                   bus.c0_tx_addr, bus.c0_tx_mdata, mTxA, mTxM);
        end
      end
      total++;
      if (bus.outstanding_zero !== expOz() || bus.tag_err !== 1'b0) begin
        bad++;
        $display("FAIL rnd_oz%0d: got %b/%b want %b/0", c,
                 bus.outstanding_zero, bus.tag_err, expOz());
      end
      randData();
      bus.req_valid      = N'($urandom());
      bus.c0TxAlmFull    = ($urandom_range(0, 7) == 0);
      bus.c0_rx_rd_valid = ($urandom_range(0, 2) == 0);
      md                 = MW'($urandom());
      bus.c0_rx_mdata    = md;
      #1;
      total++;
      if (bus.req_ready !== oneHot(expGrant())) begin
        bad++;
        $display("FAIL rnd_ready%0d: got %b want %b",
                 c, bus.req_ready, oneHot(expGrant()));
      end
      total++;
      if (bus.rsp_valid !== (bus.c0_rx_rd_valid ? oneHot(int'(md[15:14])) : 4'b0)
          || bus.rsp_mdata !== md[UW-1:0]) begin
        bad++;
        $display("FAIL rnd_rsp%0d: got %b/%h for mdata %h", c,
                 bus.rsp_valid, bus.rsp_mdata, md);
      end
      @(negedge pClk);
    end
    idle();
  endtask

  task automatic test_badtag_reset();
    idle();
    bus3.c0_rx_rd_valid = 1'b1;
    bus3.c0_rx_mdata    = 16'hC005;
    #1;
    total++;
    if (bus3.rsp_valid !== 3'b000 || bus3.rsp_mdata !== 14'h0005) begin
      bad++;
      $display("FAIL badtag_rsp: got %b/%h want 000/0005",
               bus3.rsp_valid, bus3.rsp_mdata);
    end
    @(negedge pClk);
    total++;
    if (bus3.tag_err !== 1'b1) begin
      bad++;
      $display("FAIL badtag_err: got %b want 1", bus3.tag_err);
    end
    bus3.c0_rx_mdata = 16'h8001;
    #1;
    total++;
    if (bus3.rsp_valid !== 3'b100) begin
      bad++;
      $display("FAIL goodtag3: got %b want 100", bus3.rsp_valid);
    end
    @(negedge pClk);
    bus3.c0_rx_rd_valid = 1'b0;
    total++;
    if (bus3.tag_err !== 1'b1) begin
      bad++;
      $display("FAIL badtag_sticky: got %b want 1", bus3.tag_err);
    end
    bus.req_valid = '1;
    randData();
    @(negedge pClk);
    @(negedge pClk);
    @(posedge pClk);
    #2;
    total++;
    if (bus.c0_tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL burst_active: got %b want 1", bus.c0_tx_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.c0_tx_valid !== 1'b0 || bus.c0_tx_mdata !== '0
        || bus.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_tx: got v=%b m=%h rdy=%b want 0/0/0000",
               bus.c0_tx_valid, bus.c0_tx_mdata, bus.req_ready);
    end
    total++;
    if (bus.outstanding_zero !== 4'hF || bus3.tag_err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: got oz=%b err=%b want 1111/0",
               bus.outstanding_zero, bus3.tag_err);
    end
    @(negedge pClk);
    rst = 1'b0;
    bus.req_valid      = '0;
    bus.c0_rx_rd_valid = 1'b1;
    bus.c0_rx_mdata    = {2'd0, 14'h02AA};
    #1;
    total++;
    if (bus.rsp_valid !== 4'b0001) begin
      bad++;
      $display("FAIL late_rsp: got %b want 0001", bus.rsp_valid);
    end
    @(negedge pClk);
    bus.c0_rx_rd_valid = 1'b0;
    bus.req_valid      = 4'b0001;
    #1;
    total++;
    if (bus.outstanding_zero !== 4'hF || bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL late_floor: got oz=%b rdy=%b want 1111/0001",
               bus.outstanding_zero, bus.req_ready);
    end
    @(negedge pClk);
    idle();
  endtask

  task automatic test_stats();
    doReset();
    idle();
    randData();
    bus.req_valid = 4'b0001;
    repeat (10) @(negedge pClk);
    bus.req_valid = 4'b1000;
    repeat (3) @(negedge pClk);
    idle();
    @(negedge pClk);
    total++;
    if (bus.stat_grant_cnt[31:0] !== (STATS ? 32'd10 : 32'd0)) begin
      bad++;
      $display("FAIL stat_req0: got %0d want %0d",
               bus.stat_grant_cnt[31:0], STATS ? 10 : 0);
    end
    total++;
    if (bus.stat_grant_cnt[127:96] !== (STATS ? 32'd3 : 32'd0)) begin
      bad++;
      $display("FAIL stat_req3: got %0d want %0d",
               bus.stat_grant_cnt[127:96], STATS ? 3 : 0);
    end
    total++;
    if (bus.stat_grant_cnt[95:32] !== 64'd0) begin
      bad++;
      $display("FAIL stat_idle: got %h want 0", bus.stat_grant_cnt[95:32]);
    end
  endtask

  initial begin
    idle();
    bus.req_addr  = '0;
    bus.req_mdata = '0;
    test_reset();
    test_almfull();
    test_credit();
    test_simul();
    test_random();
    test_badtag_reset();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
